// File: rtl/coin_dispense_sequencer_pkg.sv
// Shared types and constants for the coin dispense sequencer.
package coin_dispense_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_ACK,
        ST_PUSH_WAIT,
        ST_RET_ACK,
        ST_RET_WAIT,
        ST_GAP,
        ST_FINISH,
        ST_FAULT
    } state_e;

    // servo_ctrl[0] encoding
    localparam logic SERVO_BACK  = 1'b1;
    localparam logic SERVO_FRONT = 1'b0;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coin_dispense_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous flag.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two register stages; both preset to RST_VAL while in reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Coin dispenser: drives a servo back/front once per coin, with handshake
// timeouts on the servo done flags and a fixed idle gap between coins.
module coin_dispense_sequencer
    import coin_dispense_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ACK_CYCLES  = 1000,
    parameter int unsigned MOVE_CYCLES = 40_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [CNT_W-1:0] coin_count,
    input  logic             servo_back_done,
    input  logic             servo_front_done,
    output logic [31:0]      servo_ctrl,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] coins_dispensed
);

    localparam int unsigned TMR_MAX = max3(ACK_CYCLES, MOVE_CYCLES, GAP_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_CYCLES - 1);
    localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             servo_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             back_s;
    logic             front_s;
    logic             tmo_hit;

    sync2 #(.RST_VAL(1'b1)) u_sync_back (
        .clk   (clk),
        .clr_n (clr_n),
        .d_i   (servo_back_done),
        .q_o   (back_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_front (
        .clk   (clk),
        .clr_n (clr_n),
        .d_i   (servo_front_done),
        .q_o   (front_s)
    );

    // cnt_q < target_q whenever this is used, so the increment cannot wrap.
    assign cnt_d = cnt_q + 1'b1;

    // Timer reached the limit for the current state's wait.
    always_comb begin
        tmo_hit = 1'b0;
        case (state_q)
            ST_PUSH_ACK, ST_RET_ACK:   tmo_hit = (tmr_q == ACK_LAST);
            ST_PUSH_WAIT, ST_RET_WAIT: tmo_hit = (tmr_q == MOVE_LAST);
            ST_GAP:                    tmo_hit = (tmr_q == GAP_LAST);
            default:                   tmo_hit = 1'b0;
        endcase
    end

    // Sequencer FSM; outputs are registered alongside each state transition.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            servo_q  <= SERVO_FRONT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        tmr_q  <= '0;
                        busy_q <= 1'b1;
                        if (coin_count != '0) begin
                            target_q <= coin_count;
                            cnt_q    <= '0;
                            error_q  <= 1'b0;
                            servo_q  <= SERVO_BACK;
                            state_q  <= ST_PUSH_ACK;
                        end else begin
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_PUSH_ACK: begin
                    if (!back_s) begin
                        state_q <= ST_PUSH_WAIT;
                        tmr_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q <= ST_FAULT; tmr_q <= '0;
                        servo_q <= SERVO_FRONT; busy_q <= 1'b0; error_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_PUSH_WAIT: begin
                    if (back_s) begin
                        state_q <= ST_RET_ACK;
                        tmr_q   <= '0;
                        servo_q <= SERVO_FRONT;
                    end else if (tmo_hit) begin
                        state_q <= ST_FAULT; tmr_q <= '0;
                        servo_q <= SERVO_FRONT; busy_q <= 1'b0; error_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_RET_ACK: begin
                    if (!front_s) begin
                        state_q <= ST_RET_WAIT;
                        tmr_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q <= ST_FAULT; tmr_q <= '0;
                        busy_q  <= 1'b0; error_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_RET_WAIT: begin
                    if (front_s) begin
                        cnt_q   <= cnt_d;
                        tmr_q   <= '0;
                        state_q <= (cnt_d == target_q) ? ST_FINISH : ST_GAP;
                    end else if (tmo_hit) begin
                        state_q <= ST_FAULT; tmr_q <= '0;
                        busy_q  <= 1'b0; error_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmo_hit) begin
                        state_q <= ST_PUSH_ACK;
                        tmr_q   <= '0;
                        servo_q <= SERVO_BACK;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    assign servo_ctrl      = {31'd0, servo_q};
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign coins_dispensed = cnt_q;

endmodule

// File: doc/coin_dispense_sequencer.md
COIN_DISPENSE_SEQUENCER -- requirements
Module: coin_dispense_sequencer

Interface
REQ-001 Parameter CNT_W, default 8, width of coin count and dispensed counter.
REQ-002 Parameter ACK_CYCLES, default 1000, max cycles for a servo done flag to fall after a move command.
REQ-003 Parameter MOVE_CYCLES, default 40_000_000, max cycles for a servo done flag to return high after falling.
REQ-004 Parameter GAP_CYCLES, default 5_000_000, idle cycles between consecutive coins.
REQ-005 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-006 Port clr_n  input  1  reset; asynchronous assert, active-low.
REQ-007 Port start  input  1  one-cycle request to dispense coin_count coins.
REQ-008 Port coin_count  input  CNT_W  number of coins; sampled only when start is accepted.
REQ-009 Port servo_back_done  input  1  servo back-move complete flag from the servo stage; low while moving.
REQ-010 Port servo_front_done  input  1  servo front-move complete flag; low while moving.
REQ-011 Port servo_ctrl  output  32  servo command to the servo stage; bit 0 = 1 back (push), 0 front (rest); bits 31:1 always 0.
REQ-012 Port busy  output  1  high from accepted start until FINISH or FAULT.
REQ-013 Port done  output  1  one-cycle pulse when the full count has been dispensed.
REQ-014 Port error  output  1  sticky fault flag (timeout).
REQ-015 Port coins_dispensed  output  CNT_W  coins completed in the current or last job.

Function
REQ-016 The block SHALL pass servo_back_done and servo_front_done through two-flop synchronizers before use; all latencies below exclude these 2 cycles.
REQ-017 The FSM SHALL have states IDLE, PUSH_ACK, PUSH_WAIT, RET_ACK, RET_WAIT, GAP, FINISH, FAULT.
REQ-018 IDLE or FAULT with start=1 and coin_count>0: latch target, clear coins_dispensed and error, go to PUSH_ACK next cycle.
REQ-019 IDLE or FAULT with start=1 and coin_count=0: go to FINISH, no servo movement.
REQ-020 start SHALL be ignored in every state other than IDLE and FAULT.
REQ-021 servo_ctrl[0] SHALL be 1 in PUSH_ACK and PUSH_WAIT, 0 in all other states.
REQ-022 PUSH_ACK: on synced back_done=0 go PUSH_WAIT; after ACK_CYCLES cycles without it go FAULT.
REQ-023 PUSH_WAIT: on synced back_done=1 go RET_ACK; after MOVE_CYCLES cycles go FAULT.
REQ-024 RET_ACK/RET_WAIT: same rules as REQ-022/023 using front_done; on RET_WAIT exit, increment coins_dispensed.
REQ-025 After RET_WAIT: if incremented coins_dispensed equals target go FINISH, else GAP.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles then go PUSH_ACK.
REQ-027 FINISH SHALL assert done for one cycle, deassert busy, return to IDLE.
REQ-028 FAULT SHALL set error=1, busy=0, hold until start; coins_dispensed SHALL hold its value.
REQ-029 A single shared timeout counter SHALL clear on every state change; its width SHALL hold MOVE_CYCLES.
REQ-030 coins_dispensed SHALL never exceed target; no wrap at 2^CNT_W-1 target.

Reset
REQ-031 While clr_n=0: state IDLE, servo_ctrl=0, busy=0, done=0, error=0, coins_dispensed=0, counters and synchronizers cleared (synchronizers to 1).
REQ-032 Reset mid-job SHALL abort immediately, returning servo to front (servo_ctrl[0]=0); no done pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration and the servo_ctrl bit-0 encoding constants (BACK=1, FRONT=0).
REQ-034 One sub-module, sync2, SHALL implement the two-flop synchronizer, instantiated twice.

Verification (ACK_CYCLES=8, MOVE_CYCLES=50, GAP_CYCLES=10, servo model drops flag 3 cycles after command, raises 20 later)
REQ-035 start, coin_count=3 -> three back/front cycles on servo_ctrl[0], GAP of 10 cycles between, done pulse once, coins_dispensed=3, error=0.
REQ-036 start, coin_count=0 -> done pulse 2 cycles after start, servo_ctrl stays 0, busy high 1 cycle.
REQ-037 Servo model never drops back_done -> FAULT 8 cycles after PUSH_ACK entry, error=1, servo_ctrl[0]=0, coins_dispensed=0.
REQ-038 coin_count=2, model stalls front_done low on coin 2 -> FAULT after 50 cycles, coins_dispensed=1; new start clears error and restarts.
REQ-039 start pulsed again while busy with coin_count=5 -> ignored; original job of 2 completes with coins_dispensed=2.
REQ-040 clr_n low during PUSH_WAIT -> servo_ctrl=0 and all outputs reset same cycle, no done pulse after release.
